// File: rtl/maxnet_update_unit_pkg.sv
// Shared types, float field positions and the ReLU flush used by the Maxnet update unit.
package maxnet_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int          NEURONS  = 4;
  localparam int          FLT_W    = 32;
  localparam logic [31:0] FLT_ZERO = 32'h0;
  localparam int          EXP_MSB  = 30;
  localparam int          EXP_LSB  = 23;
  localparam int          SIGN_BIT = 31;

  // Negative values, signed zeros and denormals all collapse to +0.
  function automatic logic [FLT_W-1:0] relu_flush(input logic [FLT_W-1:0] v);
    logic [FLT_W-1:0] r;
    r = v;
    if (v[SIGN_BIT] || (v[EXP_MSB:EXP_LSB] == '0)) r = FLT_ZERO;
    return r;
  endfunction

endpackage

// File: rtl/maxnet_update_unit_if.sv
// Result handshake between the processing unit (master) and the update unit (slave).
interface maxnet_update_unit_if #(
  parameter int XLEN = 32
);
  logic            res_valid;
  logic            res_ready;
  logic [XLEN-1:0] res0;
  logic [XLEN-1:0] res1;
  logic [XLEN-1:0] res2;
  logic [XLEN-1:0] res3;

  modport master (output res_valid, res0, res1, res2, res3, input res_ready);
  modport slave  (input res_valid, res0, res1, res2, res3, output res_ready);
endinterface

// File: rtl/maxnet_update_unit_argmax4.sv
// Four-way unsigned maximum search (ties resolve to the lowest index) plus a non-zero count.
module maxnet_argmax4
  import maxnet_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] x0,
  input  logic [XLEN-1:0] x1,
  input  logic [XLEN-1:0] x2,
  input  logic [XLEN-1:0] x3,
  output logic [1:0]      idx,
  output logic [2:0]      nz_cnt
);

  logic [XLEN-1:0] v01;
  logic [XLEN-1:0] v23;
  logic [1:0]      i01;
  logic [1:0]      i23;

  // Strict greater-than keeps the lower index on equality at every level.
  always_comb begin
    i01 = (x1 > x0) ? 2'd1 : 2'd0;
    v01 = (x1 > x0) ? x1 : x0;
    i23 = (x3 > x2) ? 2'd3 : 2'd2;
    v23 = (x3 > x2) ? x3 : x2;
    idx = (v23 > v01) ? i23 : i01;
  end

  assign nz_cnt = {2'b0, (x0 != FLT_ZERO)} + {2'b0, (x1 != FLT_ZERO)}
                + {2'b0, (x2 != FLT_ZERO)} + {2'b0, (x3 != FLT_ZERO)};

endmodule

// File: rtl/maxnet_update_unit.sv
// Maxnet update stage: ReLU on PU results, neuron bank feedback, convergence/timeout decision.
module maxnet_update_unit
  import maxnet_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MAX_ITER = 16,
  parameter int ITW      = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [XLEN-1:0]      init_x0,
  input  logic [XLEN-1:0]      init_x1,
  input  logic [XLEN-1:0]      init_x2,
  input  logic [XLEN-1:0]      init_x3,
  maxnet_update_unit_if.slave  rif,
  output logic [XLEN-1:0]      x0,
  output logic [XLEN-1:0]      x1,
  output logic [XLEN-1:0]      x2,
  output logic [XLEN-1:0]      x3,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           winner,
  output logic                 timeout,
  output logic [ITW-1:0]       iter_cnt
);

  localparam logic [ITW-1:0] ITER_LIM = ITW'(MAX_ITER);

  state_e          state_q;
  state_e          state_d;
  logic [XLEN-1:0] bank [NEURONS];
  logic [1:0]      max_idx;
  logic [2:0]      nz_cnt;
  logic            accept;
  logic            load;

  maxnet_argmax4 #(.XLEN(XLEN)) u_argmax (
    .x0     (bank[0]),
    .x1     (bank[1]),
    .x2     (bank[2]),
    .x3     (bank[3]),
    .idx    (max_idx),
    .nz_cnt (nz_cnt)
  );

  assign rif.res_ready = (state_q == RUN);
  assign accept        = (state_q == RUN) && rif.res_valid;
  assign load          = ((state_q == IDLE) || (state_q == DONE)) && start;
  assign busy          = (state_q == RUN) || (state_q == CHECK);
  assign done          = (state_q == DONE);
  assign x0            = bank[0];
  assign x1            = bank[1];
  assign x2            = bank[2];
  assign x3            = bank[3];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (rif.res_valid) state_d = CHECK;
      CHECK:   if ((nz_cnt <= 3'd1) || (iter_cnt == ITER_LIM)) state_d = DONE;
               else state_d = RUN;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Bank, iteration counter and result registers; the bank only moves on load or accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NEURONS; i++) bank[i] <= FLT_ZERO;
      iter_cnt <= '0;
      winner   <= 2'd0;
      timeout  <= 1'b0;
    end else if (load) begin
      bank[0]  <= relu_flush(init_x0);
      bank[1]  <= relu_flush(init_x1);
      bank[2]  <= relu_flush(init_x2);
      bank[3]  <= relu_flush(init_x3);
      iter_cnt <= '0;
      timeout  <= 1'b0;
    end else if (accept) begin
      bank[0]  <= relu_flush(rif.res0);
      bank[1]  <= relu_flush(rif.res1);
      bank[2]  <= relu_flush(rif.res2);
      bank[3]  <= relu_flush(rif.res3);
      iter_cnt <= iter_cnt + 1'b1;
    end else if (state_q == CHECK) begin
      if (nz_cnt == 3'd0) begin
        winner  <= 2'd0;
        timeout <= 1'b0;
      end else if (nz_cnt == 3'd1) begin
        winner  <= max_idx;
        timeout <= 1'b0;
      end else if (iter_cnt == ITER_LIM) begin
        winner  <= max_idx;
        timeout <= 1'b1;
      end
    end
  end

endmodule
